// File: rtl/bcd_pkg.sv
// Shared definitions for the 3-digit BCD keypad entry block (bcd_entry8).
package bcd_pkg;

    // Entry controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        PUSH  = 3'd2,
        WAITF = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Most digits one entry may hold.
    localparam logic [1:0] MAX_DIGITS = 2'd3;

    // Largest value that fits the 8-bit result.
    localparam logic [9:0] MAX_VAL = 10'd255;

    // Largest legal BCD digit.
    localparam logic [3:0] MAX_BCD = 4'd9;

endpackage

// File: rtl/bcd_mac10.sv
// Decimal accumulate step: acc_o = acc_i*10 + digit_i, truncated to 10 bits.
// Built from shifts and adds, with no multiplier: (acc<<3) + (acc<<1) + digit.
module bcd_mac10 (
    input  logic [9:0] acc_i,
    input  logic [3:0] digit_i,
    output logic [9:0] acc_o
);

    // Times-eight plus times-two gives times-ten; the digit is added on top.
    always_comb begin
        acc_o = (acc_i << 3) + (acc_i << 1) + {6'd0, digit_i};
    end

endmodule

// File: rtl/bcd_entry8.sv
// bcd_entry8: collects up to three BCD digits, converts them to an 8-bit
// binary value and pushes that value to a downstream stack. The push waits
// while the stack reports full.
// Optional build macro BCD_DIGIT_CHECK_EN: when it is defined, a digit above 9
// sends the entry to ERR. When it is undefined, such a digit is added using its
// plain binary value.
module bcd_entry8
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       clear,
    input  logic       full,
    output logic [7:0] Dout,
    output logic       push,
    output logic       err,
    output logic       busy,
    output logic [1:0] ndig,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2
);

`ifdef BCD_DIGIT_CHECK_EN
    localparam bit DIGIT_CHECK = 1'b1;
`else
    localparam bit DIGIT_CHECK = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [9:0]  acc_q,   acc_d;
    logic [1:0]  ndig_q,  ndig_d;
    logic [3:0]  bcd0_q,  bcd0_d;
    logic [3:0]  bcd1_q,  bcd1_d;
    logic [3:0]  bcd2_q,  bcd2_d;
    logic [7:0]  dout_q,  dout_d;

    logic [9:0]  acc_next;
    logic        digit_bad;

    bcd_mac10 u_mac (
        .acc_i   (acc_q),
        .digit_i (digit),
        .acc_o   (acc_next)
    );

    assign digit_bad = DIGIT_CHECK && (digit > MAX_BCD);

    // Next-state and datapath update: clear wins, then per-state behaviour.
    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        bcd0_d  = bcd0_q;
        bcd1_d  = bcd1_q;
        bcd2_d  = bcd2_q;
        dout_d  = dout_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ndig_d  = '0;
            bcd0_d  = '0;
            bcd1_d  = '0;
            bcd2_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // enter is ignored here, so an empty entry pushes nothing.
                    if (digit_valid) begin
                        if (digit_bad) begin
                            state_d = ERR;
                        end else begin
                            acc_d   = acc_next;
                            ndig_d  = 2'd1;
                            bcd2_d  = bcd1_q;
                            bcd1_d  = bcd0_q;
                            bcd0_d  = digit;
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    // enter takes precedence, and a digit in the same cycle is dropped.
                    if (enter) begin
                        if (acc_q > MAX_VAL) begin
                            state_d = ERR;
                        end else begin
                            dout_d  = acc_q[7:0];
                            state_d = full ? WAITF : PUSH;
                        end
                    end else if (digit_valid) begin
                        if (digit_bad) begin
                            state_d = ERR;
                        end else if (ndig_q < MAX_DIGITS) begin
                            acc_d  = acc_next;
                            ndig_d = ndig_q + 2'd1;
                            bcd2_d = bcd1_q;
                            bcd1_d = bcd0_q;
                            bcd0_d = digit;
                        end
                    end
                end
                PUSH: begin
                    // The push strobe lasts this one cycle. The entry is then retired.
                    acc_d   = '0;
                    ndig_d  = '0;
                    bcd0_d  = '0;
                    bcd1_d  = '0;
                    bcd2_d  = '0;
                    state_d = IDLE;
                end
                WAITF: begin
                    if (!full) begin
                        state_d = PUSH;
                    end
                end
                ERR: begin
                    // Only clear (handled above) or reset leaves ERR.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, asynchronously cleared by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ndig_q  <= '0;
            bcd0_q  <= '0;
            bcd1_q  <= '0;
            bcd2_q  <= '0;
            dout_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register take its new value together at the clock edge.
            state_q <= state_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            bcd0_q  <= bcd0_d;
            bcd1_q  <= bcd1_d;
            bcd2_q  <= bcd2_d;
            dout_q  <= dout_d;
        end
    end

    // Outputs are decoded straight from registers, so reset clears them at once.
    always_comb begin
        Dout = dout_q;
        push = (state_q == PUSH);
        err  = (state_q == ERR);
        busy = (state_q != IDLE);
        ndig = ndig_q;
        BCD0 = bcd0_q;
        BCD1 = bcd1_q;
        BCD2 = bcd2_q;
    end

endmodule
